// File: rtl/memory_module.sv
// MEM pipeline stage: word-addressed data memory with registered read data and
// write-back controls, plus combinational branch resolution for the PC mux.
module memory_module #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       AddResult,
  input  logic [31:0]       ALUResult,
  input  logic [DATA_W-1:0] read_data2,
  input  logic [4:0]        exeMuxRes,
  input  logic              aluZero,
  input  logic              MemtoReg,
  input  logic              RegWrite,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              Branch,
  output logic [4:0]        exeMuxRes_out,
  output logic [DATA_W-1:0] ReadData,
  output logic [31:0]       AddResult_out,
  output logic              RegWrite_out,
  output logic              MemtoReg_out,
  output logic              PCSrc_out
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [DATA_W-1:0]    mem_q [DEPTH];
  logic [ADDR_BITS-1:0] addr_c;
  logic                 mem_we_c;
  logic                 unused_addr_c;

  logic [DATA_W-1:0]    read_data_d, read_data_q;
  logic [4:0]           dest_d, dest_q;
  logic                 reg_write_d, reg_write_q;
  logic                 mem_to_reg_d, mem_to_reg_q;

  // Upper address bits are ignored, so accesses wrap modulo the memory depth.
  always_comb begin
    addr_c        = ALUResult[ADDR_BITS-1:0];
    unused_addr_c = ^ALUResult[31:ADDR_BITS];
    mem_we_c      = rst_n & MemWrite;
    read_data_d   = '0;
    dest_d        = exeMuxRes;
    reg_write_d   = RegWrite;
    mem_to_reg_d  = MemtoReg;
    if (MemRead) begin
      read_data_d = mem_q[addr_c];
    end
  end

  // Memory is not reset; contents survive rst_n and writes are gated by it.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[addr_c] <= read_data2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      read_data_q  <= '0;
      dest_q       <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      read_data_q  <= read_data_d;
      dest_q       <= dest_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
    end
  end

  assign ReadData      = read_data_q;
  assign exeMuxRes_out = dest_q;
  assign RegWrite_out  = reg_write_q;
  assign MemtoReg_out  = mem_to_reg_q;
  assign AddResult_out = AddResult;
  assign PCSrc_out     = Branch & aluZero;

endmodule

// File: tb/tb_memory_module.sv
// Directed self-checking bench for memory_module: loads, stores, branches,
// address wrap, read-before-write and reset behaviour.
module tb_memory_module;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] AddResult, ALUResult, read_data2;
  logic [4:0]  exeMuxRes;
  logic        aluZero, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
  logic [4:0]  exeMuxRes_out;
  logic [31:0] ReadData, AddResult_out;
  logic        RegWrite_out, MemtoReg_out, PCSrc_out;

  int checks = 0;
  int errors = 0;

  memory_module #(.ADDR_BITS(8), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .AddResult(AddResult), .ALUResult(ALUResult), .read_data2(read_data2),
    .exeMuxRes(exeMuxRes), .aluZero(aluZero), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
    .exeMuxRes_out(exeMuxRes_out), .ReadData(ReadData), .AddResult_out(AddResult_out),
    .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out), .PCSrc_out(PCSrc_out)
  );

  always #5 clk = ~clk;

  // Set every input; callers then wait for an edge with step().
  task automatic drive(input logic rn, input logic [31:0] addr, input logic [31:0] wd,
                       input logic rd, input logic wr, input logic br, input logic zf,
                       input logic [4:0] dst, input logic rw, input logic m2r,
                       input logic [31:0] tgt);
    rst_n = rn; ALUResult = addr; read_data2 = wd; MemRead = rd; MemWrite = wr;
    Branch = br; aluZero = zf; exeMuxRes = dst; RegWrite = rw; MemtoReg = m2r;
    AddResult = tgt;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd31, 1'b1, 1'b1, 32'h0000_1234);
    checks++;
    if (PCSrc_out !== 1'b1) begin errors++; $display("FAIL reset_pcsrc got %b want 1", PCSrc_out); end
    checks++;
    if (AddResult_out !== 32'h0000_1234) begin errors++; $display("FAIL reset_addresult got %h want 00001234", AddResult_out); end
    step();
    step();
    checks++;
    if (ReadData !== 32'd0) begin errors++; $display("FAIL reset_readdata got %0d want 0", ReadData); end
    checks++;
    if (exeMuxRes_out !== 5'd0) begin errors++; $display("FAIL reset_dest got %0d want 0", exeMuxRes_out); end
    checks++;
    if (RegWrite_out !== 1'b0 || MemtoReg_out !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got rw=%b m2r=%b want 0 0", RegWrite_out, MemtoReg_out);
    end
  endtask

  task automatic test_store_branch();
    drive(1'b1, 32'd0, 32'd100, 1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 32'h40);
    checks++;
    if (PCSrc_out !== 1'b1) begin errors++; $display("FAIL store_taken_pcsrc got %b want 1", PCSrc_out); end
    step();
    checks++;
    if (ReadData !== 32'd0) begin errors++; $display("FAIL store_no_read got %0d want 0", ReadData); end
    drive(1'b1, 32'd1, 32'd1111, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'h44);
    checks++;
    if (PCSrc_out !== 1'b0) begin errors++; $display("FAIL store_not_taken_pcsrc got %b want 0", PCSrc_out); end
    step();
  endtask

  task automatic test_load();
    drive(1'b1, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 32'h48);
    checks++;
    if (PCSrc_out !== 1'b0) begin errors++; $display("FAIL load_pcsrc got %b want 0", PCSrc_out); end
    step();
    checks++;
    if (ReadData !== 32'd100) begin errors++; $display("FAIL load_addr0 got %0d want 100", ReadData); end
    checks++;
    if (exeMuxRes_out !== 5'd5 || RegWrite_out !== 1'b1 || MemtoReg_out !== 1'b1) begin
      errors++; $display("FAIL load_wb_ctrl got dst=%0d rw=%b m2r=%b want 5 1 1",
                         exeMuxRes_out, RegWrite_out, MemtoReg_out);
    end
    drive(1'b1, 32'd1, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 32'h4c);
    checks++;
    if (PCSrc_out !== 1'b1) begin errors++; $display("FAIL load_branch_pcsrc got %b want 1", PCSrc_out); end
    step();
    checks++;
    if (ReadData !== 32'd1111) begin errors++; $display("FAIL load_addr1 got %0d want 1111", ReadData); end
    checks++;
    if (exeMuxRes_out !== 5'd9 || RegWrite_out !== 1'b0 || MemtoReg_out !== 1'b1) begin
      errors++; $display("FAIL load_branch_wb got dst=%0d rw=%b m2r=%b want 9 0 1",
                         exeMuxRes_out, RegWrite_out, MemtoReg_out);
    end
    drive(1'b1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
    step();
    checks++;
    if (ReadData !== 32'd0) begin errors++; $display("FAIL no_read_zero got %0d want 0", ReadData); end
  endtask

  task automatic test_wrap_rbw();
    drive(1'b1, 32'h100, 32'd5, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
    step();
    drive(1'b1, 32'd0, 32'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
    step();
    checks++;
    if (ReadData !== 32'd5) begin errors++; $display("FAIL rbw_old_data got %0d want 5", ReadData); end
    drive(1'b1, 32'h200, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
    step();
    checks++;
    if (ReadData !== 32'd7) begin errors++; $display("FAIL rbw_new_data got %0d want 7", ReadData); end
    drive(1'b1, 32'hFFFF_FF01, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
    step();
    checks++;
    if (ReadData !== 32'd1111) begin errors++; $display("FAIL wrap_high_addr got %0d want 1111", ReadData); end
  endtask

  task automatic test_reset_write();
    drive(1'b0, 32'd0, 32'd99, 1'b1, 1'b1, 1'b0, 1'b1, 5'd31, 1'b1, 1'b1, 32'hDEAD_BEEF);
    checks++;
    if (AddResult_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rst_addresult got %h want deadbeef", AddResult_out); end
    step();
    checks++;
    if (ReadData !== 32'd0 || exeMuxRes_out !== 5'd0 || RegWrite_out !== 1'b0 || MemtoReg_out !== 1'b0) begin
      errors++; $display("FAIL rst_outputs got rd=%0d dst=%0d rw=%b m2r=%b want 0 0 0 0",
                         ReadData, exeMuxRes_out, RegWrite_out, MemtoReg_out);
    end
    drive(1'b1, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
    step();
    checks++;
    if (ReadData !== 32'd7) begin errors++; $display("FAIL rst_write_blocked got %0d want 7", ReadData); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] wdat [3];
    wdat[0] = 32'hA5A5_0002; wdat[1] = 32'h5A5A_0003; wdat[2] = 32'h0F0F_0004;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(i + 2), wdat[i], 1'b0, 1'b1, 1'b0, 1'b0, 5'(i + 10), 1'b1, 1'(i), 32'h0);
      step();
      checks++;
      if (exeMuxRes_out !== 5'(i + 10)) begin
        errors++; $display("FAIL b2b_wr_dest%0d got %0d want %0d", i, exeMuxRes_out, i + 10);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(i + 2), 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'(i + 20), 1'b1, 1'b1, 32'h0);
      step();
      checks++;
      if (ReadData !== wdat[i] || exeMuxRes_out !== 5'(i + 20)) begin
        errors++; $display("FAIL b2b_rd%0d got rd=%h dst=%0d want %h %0d",
                           i, ReadData, exeMuxRes_out, wdat[i], i + 20);
      end
    end
  endtask

  initial begin
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
    test_reset();
    test_store_branch();
    test_load();
    test_wrap_rbw();
    test_reset_write();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
